// File: rtl/pipelined_carry_adder_if.sv
// Handshake/operand bundle for pipelined_carry_adder; ovf exists only when PCA_OVERFLOW_EN is defined.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PCA_OVERFLOW_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef PCA_OVERFLOW_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef PCA_OVERFLOW_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder split into STAGES chunks, one chunk per pipeline stage, with a global-stall
// valid/ready handshake. Define PCA_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic                   clk,
    input logic                   rst,
    pipelined_carry_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic             adv;
    logic             accept;
    logic             vld_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign adv          = !vld_q || bus.out_ready;
    assign bus.in_ready = adv || rst;
    assign accept       = bus.in_valid && adv && !rst;

    // Each stage consumes the low chunk of its remaining operands; the next stage registers
    // only the still-unadded upper part, and finished sum chunks grow from the bottom up.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * CW;
        localparam int DW = (k + 1) * CW;

        logic [RW-1:0] ai;
        logic [RW-1:0] bi;
        logic          ci;
        logic          vi;
        logic [CW:0]   part;
        logic [DW-1:0] sn;

        if (k == 0) begin : g_in
            assign ai = bus.a;
            assign bi = bus.b;
            assign ci = bus.cin;
            assign vi = accept;
            assign sn = part[CW-1:0];
        end else begin : g_reg
            logic [RW-1:0]    a_q;
            logic [RW-1:0]    b_q;
            logic [DW-CW-1:0] s_q;
            logic             c_q;
            logic             v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    v_q <= g_st[k-1].vi;
                    a_q <= g_st[k-1].ai[RW+CW-1:CW];
                    b_q <= g_st[k-1].bi[RW+CW-1:CW];
                    s_q <= g_st[k-1].sn;
                    c_q <= g_st[k-1].part[CW];
                end
            end

            assign ai = a_q;
            assign bi = b_q;
            assign ci = c_q;
            assign vi = v_q;
            assign sn = {part[CW-1:0], s_q};
        end

        assign part = {1'b0, ai[CW-1:0]} + {1'b0, bi[CW-1:0]} + {{CW{1'b0}}, ci};
    end

`ifdef PCA_OVERFLOW_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef PCA_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
        end else if (adv) begin
            vld_q  <= g_st[L].vi;
            sum_q  <= g_st[L].sn;
            cout_q <= g_st[L].part[CW];
`ifdef PCA_OVERFLOW_EN
            // The last stage still sees both operand sign bits as the top of its chunk.
            ovf_q  <= g_st[L].vi
                      && (g_st[L].ai[CW-1] == g_st[L].bi[CW-1])
                      && (g_st[L].sn[WIDTH-1] != g_st[L].ai[CW-1]);
`endif
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef PCA_OVERFLOW_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder (WIDTH=16, STAGES=4); checks ovf when PCA_OVERFLOW_EN is defined.
module tb_pipelined_carry_adder;
    localparam int W = 16;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_carry_adder_if #(.WIDTH(W)) bus();

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic res_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        res_t   r;
        longint u;
        longint s;
        u = longint'(va) + longint'(vb) + longint'(vc);
        s = longint'($signed(va)) + longint'($signed(vb)) + longint'(vc);
        r.sum  = W'(u % (64'd1 << W));
        r.cout = (u >= (64'd1 << W));
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: records accepted inputs into the model queue and checks every output transfer.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum=%0h expected no result", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", 32'(bus.sum), 32'(e.sum));
                    chk("cout", 32'(bus.cout), 32'(e.cout));
`ifdef PCA_OVERFLOW_EN
                    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = va;
        bus.b = vb;
        bus.cin = vc;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) break;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic latency_check(input string name);
        for (int i = 1; i <= S; i++) begin
            @(negedge clk);
            chk(name, 32'(bus.out_valid), 32'(i == S));
        end
    endtask

    initial begin
        logic [W-1:0] held;
        int acc;
        int cyc;
        bit seen;

        bus.in_valid  = 1'b1;
        bus.a         = 16'hBEEF;
        bus.b         = 16'h1111;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset_sum", 32'(bus.sum), 32'(0));
        chk("reset_cout", 32'(bus.cout), 32'(0));
        chk("reset_in_ready", 32'(bus.in_ready), 32'(1));
`ifdef PCA_OVERFLOW_EN
        chk("reset_ovf", 32'(bus.ovf), 32'(0));
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b0;

        // Zero add and latency.
        send(16'h0000, 16'h0000, 1'b0);
        latency_check("latency_zero");
        drain();

        // Full carry chains.
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1);
`ifdef PCA_OVERFLOW_EN
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
`endif
        drain();

        // Eight back-to-back pairs: in_ready stays high, results emerge consecutively.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 16'(16'h1000 * i + 16'h0FF1);
            bus.b = 16'(16'h0F0F + i);
            bus.cin = 1'(i);
            @(negedge clk);
            chk("stream_in_ready", 32'(bus.in_ready), 32'(1));
            chk("stream_out_valid", 32'(bus.out_valid), 32'(i >= S));
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            chk("stream_tail_valid", 32'(bus.out_valid), 32'(1));
        end
        @(negedge clk);
        chk("stream_end_valid", 32'(bus.out_valid), 32'(0));
        drain();

        // Backpressure: output held stable and input blocked while out_ready is low.
        send(16'h1111, 16'h2222, 1'b0);
        send(16'hF00F, 16'h0FF1, 1'b1);
        send(16'h8001, 16'h7FFF, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 16'h5555;
        bus.b = 16'hAAAA;
        bus.cin = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_out_valid_seen", 32'(seen), 32'(1));
        held = bus.sum;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
            chk("bp_sum_stable", 32'(bus.sum), 32'(held));
            chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        drain();

        // Reset with three entries in flight; input offered during reset is ignored.
        send(16'h0101, 16'h0202, 1'b0);
        send(16'h0303, 16'h0404, 1'b0);
        send(16'h0505, 16'h0606, 1'b1);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.a = 16'hDEAD;
        bus.b = 16'h0001;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_mid_sum", 32'(bus.sum), 32'(0));
        @(posedge clk);
        #1;
        send(16'h1234, 16'h0001, 1'b0);
        latency_check("latency_post_rst");
        chk("post_rst_sum", 32'(bus.sum), 32'(16'h1235));
        drain();

        // Random traffic with random backpressure.
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            bus.in_valid = ($urandom_range(3) != 0);
            bus.a = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            bus.b = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
            bus.cin = 1'($urandom);
            bus.out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("random_accepted", 32'(acc), 32'(1000));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
